// File: rtl/prim_ram_1p_arb_pkg.sv
// prim_ram_1p_arb_pkg
//   Shared constants and helpers for the single-port RAM arbiter.
//   - RerrW : width of the RAM error report {uncorrectable, correctable}
//   - vbits : bits needed to hold an index in 0..value-1 (at least 1)
package prim_ram_1p_arb_pkg;

   localparam int unsigned RerrW = 2;

   function automatic int unsigned vbits(input int unsigned value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

endpackage

// File: rtl/prim_ram_1p_arb_rr.sv
// prim_ram_1p_arb_rr
//   Purely combinational round-robin picker.
//   Ports:
//     req  in  NumReq  request vector
//     prio in  IdW     index that gets first pick this cycle
//     gnt  out NumReq  one-hot grant (all zero without any request)
//     id   out IdW     index of the granted requester (0 without grant)
module prim_ram_1p_arb_rr
   import prim_ram_1p_arb_pkg::*;
#(
   parameter int unsigned NumReq = 2
) (
   input  logic [NumReq-1:0]        req,
   input  logic [vbits(NumReq)-1:0] prio,
   output logic [NumReq-1:0]        gnt,
   output logic [vbits(NumReq)-1:0] id
);

   localparam int unsigned IdW = vbits(NumReq);

   logic           found;
   logic [IdW:0]   sum;
   logic [IdW-1:0] idx;

   // Walk upward from prio with wrap-around; the first requester seen wins.
   // The sum carries one extra bit so the wrap compare cannot overflow.
   always_comb begin
      gnt   = '0;
      id    = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < int'(NumReq); k++) begin
         sum = {1'b0, prio} + (IdW+1)'(k);
         if (sum >= (IdW+1)'(NumReq)) begin
            sum = sum - (IdW+1)'(NumReq);
         end
         idx = sum[IdW-1:0];
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            id       = idx;
         end
      end
   end

endmodule

// File: rtl/prim_ram_1p_arb.sv
// prim_ram_1p_arb
//   Round-robin arbiter sharing one single-port RAM wrapper between NumReq
//   requesters. One access per cycle; reads are tracked in an ID pipeline
//   matched to the RAM read latency so each response returns to its issuer.
//   Ports:
//     clk_i, rst_ni                 clock, asynchronous active-low reset
//     req_i/gnt_o                   per-requester request and same-cycle grant
//     write_i/addr_i/wdata_i/wmask_i per-requester access fields
//     rvalid_o/rdata_o/rerror_o     per-requester read response
//     rsp_err_o                     sticky: RAM rvalid disagreed with tracking
//     ram_*_o                       request side of the RAM wrapper
//     ram_rvalid_i/rdata_i/rerror_i response side of the RAM wrapper
//
// Handshake: an access is accepted in exactly the cycle where req_i[i] and
// gnt_o[i] are both high. A requester that is not granted keeps req_i high
// and its fields stable and retries. There is no backpressure on responses:
// rvalid_o[i] is a single-cycle strobe that must be consumed when seen.
module prim_ram_1p_arb
   import prim_ram_1p_arb_pkg::*;
#(
   parameter int unsigned NumReq      = 2,
   parameter int unsigned Aw          = 9,
   parameter int unsigned Width       = 32,
   parameter int unsigned RdLatency   = 1,
   parameter bit          CheckRspErr = 1'b1
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   input  logic [NumReq-1:0]                  req_i,
   output logic [NumReq-1:0]                  gnt_o,
   input  logic [NumReq-1:0]                  write_i,
   input  logic [NumReq-1:0][Aw-1:0]          addr_i,
   input  logic [NumReq-1:0][Width-1:0]       wdata_i,
   input  logic [NumReq-1:0][Width-1:0]       wmask_i,
   output logic [NumReq-1:0]                  rvalid_o,
   output logic [NumReq-1:0][Width-1:0]       rdata_o,
   output logic [NumReq-1:0][RerrW-1:0]       rerror_o,
   output logic                               rsp_err_o,
   output logic                               ram_req_o,
   output logic                               ram_write_o,
   output logic [Aw-1:0]                      ram_addr_o,
   output logic [Width-1:0]                   ram_wdata_o,
   output logic [Width-1:0]                   ram_wmask_o,
   input  logic                               ram_rvalid_i,
   input  logic [Width-1:0]                   ram_rdata_i,
   input  logic [RerrW-1:0]                   ram_rerror_i
);

   localparam int unsigned IdW = vbits(NumReq);

   logic [IdW-1:0]                prio_q;
   logic [IdW-1:0]                gnt_id;
   logic                          gnt_any;
   logic [RdLatency-1:0]          pipe_valid_q;
   logic [RdLatency-1:0][IdW-1:0] pipe_id_q;
   logic                          tail_valid;
   logic [IdW-1:0]                tail_id;
   logic                          rsp_err_q;

   // ---------------------------------------------------------------------
   // Arbitration
   // ---------------------------------------------------------------------
   prim_ram_1p_arb_rr #(
      .NumReq (NumReq)
   ) u_rr (
      .req  (req_i),
      .prio (prio_q),
      .gnt  (gnt_o),
      .id   (gnt_id)
   );

   // Any request is always granted because the RAM never stalls.
   assign gnt_any   = |req_i;
   assign ram_req_o = gnt_any;

   always_comb begin
      ram_write_o = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      ram_wmask_o = '0;
      if (gnt_any) begin
         ram_write_o = write_i[gnt_id];
         ram_addr_o  = addr_i[gnt_id];
         ram_wdata_o = wdata_i[gnt_id];
         ram_wmask_o = wmask_i[gnt_id];
      end
   end

   // The winner moves to lowest priority; a lone requester still wins every
   // cycle because the search wraps back to it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prio_q <= '0;
      end else if (gnt_any) begin
         prio_q <= (gnt_id == IdW'(NumReq - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   // ---------------------------------------------------------------------
   // Read tracking: one stage per cycle of RAM read latency, so the tail
   // lines up with ram_rvalid_i. Writes enter as bubbles.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pipe_valid_q <= '0;
         pipe_id_q    <= '0;
      end else begin
         pipe_valid_q[0] <= gnt_any & ~ram_write_o;
         pipe_id_q[0]    <= gnt_id;
         for (int i = 1; i < int'(RdLatency); i++) begin
            pipe_valid_q[i] <= pipe_valid_q[i-1];
            pipe_id_q[i]    <= pipe_id_q[i-1];
         end
      end
   end

   assign tail_valid = pipe_valid_q[RdLatency-1];
   assign tail_id    = pipe_id_q[RdLatency-1];

   // Responses are only forwarded when tracking and RAM agree; a lone
   // ram_rvalid_i or a missing one is reported instead of delivered.
   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      rerror_o = '0;
      if (tail_valid && ram_rvalid_i) begin
         rvalid_o[tail_id] = 1'b1;
         rdata_o[tail_id]  = ram_rdata_i;
         rerror_o[tail_id] = ram_rerror_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_err_q <= 1'b0;
      end else if (tail_valid != ram_rvalid_i) begin
         rsp_err_q <= 1'b1;
      end
   end

   assign rsp_err_o = rsp_err_q;

   // ---------------------------------------------------------------------
   // Assertions
   // ---------------------------------------------------------------------
   rd_latency_range_a: assert property (@(posedge clk_i)
      (RdLatency >= 1) && (RdLatency <= 3));

   gnt_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(gnt_o));

   gnt_has_req_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (gnt_o & ~req_i) == '0);

   if (CheckRspErr) begin : g_rsp_err_chk
      rsp_err_never_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
         !$rose(rsp_err_o));
   end

endmodule

// File: tb/tb_prim_ram_1p_arb.sv
// tb_prim_ram_1p_arb
//   Two arbiter instances: A (NumReq=2, RdLatency=1) and B (NumReq=3,
//   RdLatency=3), each in front of a behavioural RAM. A reference model
//   tracks expected grants and responses; directed literal checks pin it.
module tb_prim_ram_1p_arb;

   localparam int Aw    = 9;
   localparam int Width = 32;

   typedef struct {
      int               due;
      int               id;
      logic [Width-1:0] data;
      logic [1:0]       err;
   } rsp_t;

   logic clk;
   logic rst_n;

   // stimulus, index 0 = DUT A, 1 = DUT B (A uses the low two lanes)
   logic [2:0]            req   [2];
   logic [2:0]            wr    [2];
   logic [2:0][Aw-1:0]    addr  [2];
   logic [2:0][Width-1:0] wdata [2];
   logic [2:0][Width-1:0] wmask [2];
   logic                  force_rv [2];
   logic                  flip [2][512];

   // DUT outputs
   logic [1:0]            gnt_a, rvalid_a;
   logic [1:0][Width-1:0] rdata_a;
   logic [1:0][1:0]       rerror_a;
   logic [2:0]            gnt_b, rvalid_b;
   logic [2:0][Width-1:0] rdata_b;
   logic [2:0][1:0]       rerror_b;
   logic                  rsp_err_a, rsp_err_b;
   logic [2:0]            gnt    [2];
   logic [2:0]            rvalid [2];
   logic [2:0][Width-1:0] rdata  [2];
   logic [2:0][1:0]       rerror [2];
   logic                  rsp_err [2];

   // RAM side
   logic             ram_req    [2];
   logic             ram_write  [2];
   logic [Aw-1:0]    ram_addr   [2];
   logic [Width-1:0] ram_wdata  [2];
   logic [Width-1:0] ram_wmask  [2];
   logic             ram_rvalid [2];
   logic [Width-1:0] ram_rdata  [2];
   logic [1:0]       ram_rerror [2];

   // behavioural RAM
   logic [Width-1:0]      rmem  [2][512];
   logic                  rseen [2][512];
   logic [2:0]            pv [2];
   logic [2:0][Width-1:0] pd [2];
   logic [2:0][1:0]       pe [2];

   // reference model
   int               cyc = 0;
   int               m_prio [2];
   logic             m_err  [2];
   logic [Width-1:0] m_mem  [2][512];
   logic             m_wr   [2][512];
   rsp_t             exp_q  [2][$];

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   prim_ram_1p_arb #(.NumReq(2), .Aw(Aw), .Width(Width), .RdLatency(1), .CheckRspErr(1'b0)) u_dut_a (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_i        (req[0][1:0]),
      .gnt_o        (gnt_a),
      .write_i      (wr[0][1:0]),
      .addr_i       (addr[0][1:0]),
      .wdata_i      (wdata[0][1:0]),
      .wmask_i      (wmask[0][1:0]),
      .rvalid_o     (rvalid_a),
      .rdata_o      (rdata_a),
      .rerror_o     (rerror_a),
      .rsp_err_o    (rsp_err_a),
      .ram_req_o    (ram_req[0]),
      .ram_write_o  (ram_write[0]),
      .ram_addr_o   (ram_addr[0]),
      .ram_wdata_o  (ram_wdata[0]),
      .ram_wmask_o  (ram_wmask[0]),
      .ram_rvalid_i (ram_rvalid[0]),
      .ram_rdata_i  (ram_rdata[0]),
      .ram_rerror_i (ram_rerror[0])
   );

   prim_ram_1p_arb #(.NumReq(3), .Aw(Aw), .Width(Width), .RdLatency(3), .CheckRspErr(1'b1)) u_dut_b (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .req_i        (req[1]),
      .gnt_o        (gnt_b),
      .write_i      (wr[1]),
      .addr_i       (addr[1]),
      .wdata_i      (wdata[1]),
      .wmask_i      (wmask[1]),
      .rvalid_o     (rvalid_b),
      .rdata_o      (rdata_b),
      .rerror_o     (rerror_b),
      .rsp_err_o    (rsp_err_b),
      .ram_req_o    (ram_req[1]),
      .ram_write_o  (ram_write[1]),
      .ram_addr_o   (ram_addr[1]),
      .ram_wdata_o  (ram_wdata[1]),
      .ram_wmask_o  (ram_wmask[1]),
      .ram_rvalid_i (ram_rvalid[1]),
      .ram_rdata_i  (ram_rdata[1]),
      .ram_rerror_i (ram_rerror[1])
   );

   assign gnt[0]     = {1'b0, gnt_a};
   assign gnt[1]     = gnt_b;
   assign rvalid[0]  = {1'b0, rvalid_a};
   assign rvalid[1]  = rvalid_b;
   assign rdata[0]   = {{Width{1'b0}}, rdata_a};
   assign rdata[1]   = rdata_b;
   assign rerror[0]  = {2'b00, rerror_a};
   assign rerror[1]  = rerror_b;
   assign rsp_err[0] = rsp_err_a;
   assign rsp_err[1] = rsp_err_b;

   // ---------------- helpers ----------------
   function automatic int nreq(input int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic int nlat(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   // default RAM content: recognisable tag plus address
   function automatic logic [Width-1:0] seed(input logic [Aw-1:0] a);
      return {16'hA5A5, 7'b0, a};
   endfunction

   function automatic logic [Width-1:0] ram_word(input int d, input logic [Aw-1:0] a);
      return rseen[d][a] ? rmem[d][a] : seed(a);
   endfunction

   function automatic logic [Width-1:0] model_word(input int d, input logic [Aw-1:0] a);
      return m_wr[d][a] ? m_mem[d][a] : seed(a);
   endfunction

   // first requester at or after p (wrapping) wins; -1 when none requests
   function automatic int rr_pick(input logic [2:0] r, input int p, input int n);
      for (int k = 0; k < n; k++) begin
         if (r[(p + k) % n]) return (p + k) % n;
      end
      return -1;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural RAM (ECC-corrected data, flagged flips) ----------------
   assign ram_rvalid[0] = pv[0][0] | force_rv[0];
   assign ram_rdata[0]  = pd[0][0];
   assign ram_rerror[0] = pe[0][0];
   assign ram_rvalid[1] = pv[1][2] | force_rv[1];
   assign ram_rdata[1]  = pd[1][2];
   assign ram_rerror[1] = pe[1][2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            pv[d] <= '0;
            for (int a = 0; a < 512; a++) rseen[d][a] <= 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            pv[d] <= {pv[d][1:0], ram_req[d] & ~ram_write[d]};
            pd[d] <= {pd[d][1:0], ram_word(d, ram_addr[d])};
            pe[d] <= {pe[d][1:0], flip[d][ram_addr[d]] ? 2'b01 : 2'b00};
            if (ram_req[d] && ram_write[d]) begin
               rmem[d][ram_addr[d]]  <= (ram_word(d, ram_addr[d]) & ~ram_wmask[d]) | (ram_wdata[d] & ram_wmask[d]);
               rseen[d][ram_addr[d]] <= 1'b1;
            end
         end
      end
   end

   // ---------------- reference model ----------------
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < 2; d++) begin
            m_prio[d] = 0;
            m_err[d]  = 1'b0;
            exp_q[d].delete();
            for (int a = 0; a < 512; a++) m_wr[d][a] = 1'b0;
         end
      end else begin
         for (int d = 0; d < 2; d++) begin
            int   id;
            logic due_now;
            rsp_t r;
            due_now = (exp_q[d].size() > 0) && (exp_q[d][0].due == cyc);
            if (ram_rvalid[d] != due_now) m_err[d] = 1'b1;
            if (due_now) void'(exp_q[d].pop_front());
            id = rr_pick(req[d], m_prio[d], nreq(d));
            if (id >= 0) begin
               if (wr[d][id]) begin
                  m_mem[d][addr[d][id]] = (model_word(d, addr[d][id]) & ~wmask[d][id]) | (wdata[d][id] & wmask[d][id]);
                  m_wr[d][addr[d][id]]  = 1'b1;
               end else begin
                  r.due  = cyc + nlat(d);
                  r.id   = id;
                  r.data = model_word(d, addr[d][id]);
                  r.err  = flip[d][addr[d][id]] ? 2'b01 : 2'b00;
                  exp_q[d].push_back(r);
               end
               m_prio[d] = (id + 1) % nreq(d);
            end
         end
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         int                    id;
         logic [2:0]            e_gnt, e_rv;
         logic [2:0][Width-1:0] e_rd;
         logic [2:0][1:0]       e_re;
         logic                  e_wr;
         logic [Aw-1:0]         e_addr;
         logic [Width-1:0]      e_wd;
         id     = rr_pick(req[d], m_prio[d], nreq(d));
         e_gnt  = '0;
         e_rv   = '0;
         e_rd   = '0;
         e_re   = '0;
         e_wr   = 1'b0;
         e_addr = '0;
         e_wd   = '0;
         if (id >= 0) begin
            e_gnt[id] = 1'b1;
            e_wr      = wr[d][id];
            e_addr    = addr[d][id];
            e_wd      = wdata[d][id];
         end
         if (exp_q[d].size() > 0 && exp_q[d][0].due == cyc) begin
            e_rv[exp_q[d][0].id] = 1'b1;
            e_rd[exp_q[d][0].id] = exp_q[d][0].data;
            e_re[exp_q[d][0].id] = exp_q[d][0].err;
         end
         check($sformatf("gnt d%0d c%0d", d, cyc), 128'(gnt[d]), 128'(e_gnt));
         check($sformatf("rvalid d%0d c%0d", d, cyc), 128'(rvalid[d]), 128'(e_rv));
         check($sformatf("rdata d%0d c%0d", d, cyc), 128'(rdata[d]), 128'(e_rd));
         check($sformatf("rerror d%0d c%0d", d, cyc), 128'(rerror[d]), 128'(e_re));
         check($sformatf("rsp_err d%0d c%0d", d, cyc), 128'(rsp_err[d]), 128'(m_err[d]));
         check($sformatf("ram_req d%0d c%0d", d, cyc), 128'(ram_req[d]), 128'(id >= 0));
         check($sformatf("ram_write d%0d c%0d", d, cyc), 128'(ram_write[d]), 128'(e_wr));
         check($sformatf("ram_addr d%0d c%0d", d, cyc), 128'(ram_addr[d]), 128'(e_addr));
         check($sformatf("ram_wdata d%0d c%0d", d, cyc), 128'(ram_wdata[d]), 128'(e_wd));
      end
   end

   // ---------------- directed stimulus with literal expectations ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req[d]      = '0;
         wr[d]       = '0;
         addr[d]     = '0;
         wdata[d]    = '0;
         wmask[d]    = '1;
         force_rv[d] = 1'b0;
         for (int a = 0; a < 512; a++) flip[d][a] = 1'b0;
      end
      #2;
      rst_n = 1'b0;

      // reset state
      @(negedge clk);
      check("reset gnt_a", 128'(gnt_a), 128'h0);
      check("reset rvalid_a", 128'(rvalid_a), 128'h0);
      check("reset rvalid_b", 128'(rvalid_b), 128'h0);
      check("reset rsp_err_a", 128'(rsp_err_a), 128'h0);
      tick();
      rst_n = 1'b1;

      // A: both requesters read continuously for four grants
      req[0]     = 3'b011;
      addr[0][0] = 9'h010;
      addr[0][1] = 9'h020;
      for (int i = 0; i < 5; i++) begin
         logic [1:0] eg, ev;
         @(negedge clk);
         eg = (i == 4) ? 2'b00 : ((i % 2 == 0) ? 2'b01 : 2'b10);
         ev = (i == 0) ? 2'b00 : (((i - 1) % 2 == 0) ? 2'b01 : 2'b10);
         check($sformatf("alt gnt_a %0d", i), 128'(gnt_a), 128'(eg));
         check($sformatf("alt rvalid_a %0d", i), 128'(rvalid_a), 128'(ev));
         if (ev[0]) check($sformatf("alt rdata_a0 %0d", i), 128'(rdata_a[0]), 128'h A5A5_0010);
         if (ev[1]) check($sformatf("alt rdata_a1 %0d", i), 128'(rdata_a[1]), 128'h A5A5_0020);
         tick();
         if (i == 3) req[0] = '0;
      end

      // B: write 0xDEADBEEF to 0x5 from requester 0, read back on requester 1
      req[1]      = 3'b001;
      wr[1]       = 3'b001;
      addr[1][0]  = 9'h005;
      wdata[1][0] = 32'hDEAD_BEEF;
      @(negedge clk);
      check("wr gnt_b", 128'(gnt_b), 128'h1);
      tick();
      req[1]     = 3'b010;
      wr[1]      = 3'b000;
      addr[1][1] = 9'h005;
      @(negedge clk);
      check("rd gnt_b", 128'(gnt_b), 128'h2);
      check("rd rvalid_b at grant", 128'(rvalid_b), 128'h0);
      tick();
      req[1] = '0;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         if (k < 3) begin
            check($sformatf("lat3 rvalid_b +%0d", k), 128'(rvalid_b), 128'h0);
         end else begin
            check("lat3 rvalid_b +3", 128'(rvalid_b), 128'h2);
            check("lat3 rdata_b1", 128'(rdata_b[1]), 128'h DEAD_BEEF);
         end
      end

      // A: corrected single-bit error on requester 1
      tick();
      flip[0][9'h030] = 1'b1;
      req[0]          = 3'b010;
      addr[0][1]      = 9'h030;
      @(negedge clk);
      check("ecc gnt_a", 128'(gnt_a), 128'h2);
      tick();
      req[0] = '0;
      @(negedge clk);
      check("ecc rvalid_a", 128'(rvalid_a), 128'h2);
      check("ecc rerror_a1", 128'(rerror_a[1]), 128'h1);
      check("ecc rerror_a0", 128'(rerror_a[0]), 128'h0);
      check("ecc rdata_a1", 128'(rdata_a[1]), 128'h A5A5_0030);

      // A: unexpected RAM rvalid with nothing in flight
      tick();
      force_rv[0] = 1'b1;
      @(negedge clk);
      check("spurious rvalid_a", 128'(rvalid_a), 128'h0);
      check("spurious rsp_err_a same cycle", 128'(rsp_err_a), 128'h0);
      tick();
      force_rv[0] = 1'b0;
      @(negedge clk);
      check("rsp_err_a next cycle", 128'(rsp_err_a), 128'h1);
      repeat (3) @(negedge clk);
      check("rsp_err_a sticky", 128'(rsp_err_a), 128'h1);

      // B: three reads in flight, then asynchronous reset mid-cycle
      tick();
      req[1]     = 3'b111;
      addr[1][0] = 9'h040;
      addr[1][1] = 9'h041;
      addr[1][2] = 9'h042;
      repeat (3) @(posedge clk);
      req[1] = '0;
      #1;
      // prio was 2 after the read-back, so requester 2 went first
      check("pre-reset rvalid_b", 128'(rvalid_b), 128'h4);
      check("pre-reset rdata_b2", 128'(rdata_b[2]), 128'h A5A5_0042);
      #2;
      rst_n = 1'b0;
      #1;
      check("async rst gnt_b", 128'(gnt_b), 128'h0);
      check("async rst rvalid_b", 128'(rvalid_b), 128'h0);
      check("async rst rdata_b", 128'(rdata_b), 128'h0);
      check("async rst rerror_b", 128'(rerror_b), 128'h0);
      check("async rst ram_req_b", 128'(ram_req[1]), 128'h0);
      check("async rst rsp_err_a", 128'(rsp_err_a), 128'h0);
      tick();
      tick();
      rst_n = 1'b1;

      // After reset: prio back at 0, no stale responses, 101 pattern on B
      req[0]     = 3'b011;
      req[1]     = 3'b101;
      addr[1][0] = 9'h060;
      addr[1][2] = 9'h062;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("p101 gnt_b %0d", i), 128'(gnt_b), (i % 2 == 0) ? 128'h1 : 128'h4);
         if (i < 3) check($sformatf("no stale rvalid_b %0d", i), 128'(rvalid_b), 128'h0);
         else       check("p101 first rvalid_b", 128'(rvalid_b), 128'h1);
         if (i == 0) check("post-reset gnt_a", 128'(gnt_a), 128'h1);
         tick();
         if (i == 0) req[0] = '0;
         if (i == 3) req[1] = '0;
      end
      repeat (6) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
